seven_segment_mux: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 10 +
 rtl/seven_segment.sv | 9 +
 rtl/seven_segment_mux.sv | 67 ++++++
 tb/tb_seven_segment_mux.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment types, blank pattern and the active-low hex glyph table.
package seven_seg_pkg;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_OFF = 8'hFF;
  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seven_segment.sv
// seven_segment: combinational hex nibble to active-low a..g segment decoder.
module seven_segment
  import seven_seg_pkg::*;
(
  input  logic [3:0] data,
  output logic [6:0] segment
);
  assign segment = HEX_SEG[data];
endmodule

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: frame-shadowed, time-multiplexed N-digit common-anode hex display driver.
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]           count;
  logic [SW-1:0]           sel;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_en;
  logic                    load_pending;
  logic                    last_cnt, last_sel, cap, dark;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   an_nxt;
  seg_t                    seg_nxt;
  seven_segment u_dec (.data(nib), .segment(glyph));
  // A capture happens on the edge where digit_sel wraps back to 0, or on the first edge out of reset.
  always_comb begin
    last_cnt = count == CW'(REFRESH_CYCLES - 1);
    last_sel = sel == SW'(NUM_DIGITS - 1);
    cap      = load_pending | (last_cnt & last_sel);
    nib      = sh_data[4*sel +: 4];
    dark     = blank | (count < CW'(BLANK_CYCLES)) | ~sh_en[sel];
    an_nxt   = dark ? '1 : ~(NUM_DIGITS'(1) << sel);
    seg_nxt  = dark ? SEG_OFF : {~sh_dp[sel], glyph};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      sel          <= '0;
      sh_data      <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      load_pending <= 1'b1;
      frame_done   <= 1'b0;
      anode        <= '1;
      segment      <= SEG_OFF;
    end else begin
      count        <= last_cnt ? '0 : count + CW'(1);
      sel          <= last_cnt ? (last_sel ? '0 : sel + SW'(1)) : sel;
      load_pending <= 1'b0;
      frame_done   <= cap;
      anode        <= an_nxt;
      segment      <= seg_nxt;
      if (cap) begin
        sh_data <= data;
        sh_dp   <= dp;
        sh_en   <= digit_en;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_mux.sv
// tb_seven_segment_mux: directed and table-driven checks of the multiplexed display driver.
module tb_seven_segment_mux;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = 16'h1A3F;
  logic [3:0]  dp = 4'b0100;
  logic [3:0]  en = 4'hF;
  logic        blank = 1'b0;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic        frame_done;
  int          checks = 0;
  int          fails = 0;
  typedef struct { logic [3:0] nib; logic dpb; logic [7:0] seg; } dec_t;
  typedef struct { logic [3:0] an; logic [7:0] seg; } dig_t;
  dec_t dv [16];
  dig_t sw [4];
  seven_segment_mux #(.NUM_DIGITS(4), .REFRESH_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .digit_en(en), .blank(blank),
    .segment(segment), .anode(anode), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask
  task automatic wait_fd;
    int n = 0;
    tick;
    while (!frame_done && n < 40) begin
      tick;
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int last_fd;
    bit saw0, saw2;
    dv[0]  = '{4'h0, 1'b0, 8'hC0}; dv[1]  = '{4'h1, 1'b1, 8'h79};
    dv[2]  = '{4'h2, 1'b0, 8'hA4}; dv[3]  = '{4'h3, 1'b1, 8'h30};
    dv[4]  = '{4'h4, 1'b0, 8'h99}; dv[5]  = '{4'h5, 1'b1, 8'h12};
    dv[6]  = '{4'h6, 1'b0, 8'h82}; dv[7]  = '{4'h7, 1'b1, 8'h78};
    dv[8]  = '{4'h8, 1'b0, 8'h80}; dv[9]  = '{4'h9, 1'b1, 8'h10};
    dv[10] = '{4'hA, 1'b0, 8'h88}; dv[11] = '{4'hB, 1'b1, 8'h03};
    dv[12] = '{4'hC, 1'b0, 8'hC6}; dv[13] = '{4'hD, 1'b1, 8'h21};
    dv[14] = '{4'hE, 1'b0, 8'h86}; dv[15] = '{4'hF, 1'b1, 8'h0E};
    sw[0] = '{4'b1110, 8'h8E};
    sw[1] = '{4'b1101, 8'hB0};
    sw[2] = '{4'b1011, 8'h08};
    sw[3] = '{4'b0111, 8'hF9};
    #2 reset = 1'b1;
    #1;
    chk("reset_anode", anode, 4'hF);
    chk("reset_segment", segment, 8'hFF);
    chk("reset_frame_done", frame_done, 0);
    @(negedge clk) reset = 1'b0;
    ticks(4);
    chk("pre_reset_lit", anode, 4'b1110);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("midslot_reset_anode", anode, 4'hF);
    chk("midslot_reset_segment", segment, 8'hFF);
    chk("midslot_reset_fd", frame_done, 0);
    ticks(2);
    @(negedge clk) reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      int  d;
      bit  lit;
      tick;
      d   = (k - 1) / 8;
      lit = ((k - 1) % 8) >= 2;
      chk("sweep_anode", anode, lit ? sw[d].an : 4'hF);
      chk("sweep_segment", segment, lit ? sw[d].seg : 8'hFF);
      chk("sweep_frame_done", frame_done, (k == 1 || k == 32));
    end
    data = 16'h0000;
    dp   = 4'b0000;
    wait_fd;
    ticks(10);
    data = 16'hFFFF;
    ticks(9);
    chk("shadow_d2_anode", anode, 4'b1011);
    chk("shadow_d2_segment", segment, 8'hC0);
    ticks(8);
    chk("shadow_d3_anode", anode, 4'b0111);
    chk("shadow_d3_segment", segment, 8'hC0);
    ticks(5);
    chk("shadow_frame_done", frame_done, 1);
    ticks(3);
    chk("shadow_new_anode", anode, 4'b1110);
    chk("shadow_new_segment", segment, 8'h8E);
    for (int i = 0; i < 16; i++) begin
      data = {4{dv[i].nib}};
      dp   = {4{dv[i].dpb}};
      wait_fd;
      ticks(3);
      chk("decode_anode", anode, 4'b1110);
      chk("decode_segment", segment, dv[i].seg);
    end
    en = 4'b0101;
    wait_fd;
    saw0 = 0;
    saw2 = 0;
    for (int j = 1; j <= 32; j++) begin
      tick;
      chk("enable_dark_digit", (anode == 4'b1101) || (anode == 4'b0111), 0);
      if (anode == 4'b1110) saw0 = 1;
      if (anode == 4'b1011) saw2 = 1;
    end
    chk("enable_digit0_lit", saw0, 1);
    chk("enable_digit2_lit", saw2, 1);
    en = 4'hF;
    wait_fd;
    ticks(3);
    chk("blank_pre_lit", anode, 4'b1110);
    blank = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      chk("blank_anode", anode, 4'hF);
      chk("blank_segment", segment, 8'hFF);
    end
    blank = 1'b0;
    tick;
    chk("blank_release_anode", anode, 4'b1110);
    ticks(24);
    chk("blank_timing_fd_early", frame_done, 0);
    tick;
    chk("blank_timing_fd", frame_done, 1);
    last_fd = -1;
    for (int i = 0; i < 1000; i++) begin
      data  = 16'($urandom);
      dp    = 4'($urandom);
      en    = 4'($urandom);
      blank = ($urandom_range(0, 7) == 0);
      tick;
      chk("onehot_anode", $countones(~anode) <= 1, 1);
      if (frame_done) begin
        if (last_fd >= 0) chk("frame_period", i - last_fd, 32);
        last_fd = i;
      end
    end
    chk("random_frames_seen", last_fd >= 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
